// File: rtl/alu_pkg.sv
// Shared opcode enum and width constant for the execute-stage ALU.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ops;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + (b ^ {sub}) + sub, with carry-out and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] bop;

    // Invert B and inject the carry-in for subtraction so both ops share one adder.
    always_comb begin
        bop          = b ^ {WIDTH{sub}};
        {carry, sum} = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
        ovf          = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// RV32 integer ALU: combinational Result/Zero plus a clocked status register.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic             En,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [WIDTH-1:0] Result_q,
    output logic             Zero_q,
    output logic             Carry_q,
    output logic             Ovf_q
);

    localparam int SHW = $clog2(WIDTH);

    alu_ops           op;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             add_carry;
    logic             add_ovf;
    logic [SHW-1:0]   shamt;
    logic             carry;
    logic             ovf;

    assign op    = alu_ops'(ALUControl);
    assign shamt = B[SHW-1:0];
    // Compares reuse the subtractor, so they also need sub asserted.
    assign sub   = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (A),
        .b     (B),
        .sub   (sub),
        .sum   (sum),
        .carry (add_carry),
        .ovf   (add_ovf)
    );

    // Result mux and flag selection; illegal codes fall through to zero result, no flags.
    always_comb begin
        Result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD:  begin Result = sum; carry = add_carry; ovf = add_ovf; end
            ALU_SUB:  begin Result = sum; carry = add_carry; ovf = add_ovf; end
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_XOR:  Result = A ^ B;
            // Sign of difference corrected by overflow keeps SLT right at the extremes.
            ALU_SLT:  begin Result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf}; carry = add_carry; end
            ALU_SLTU: begin Result = {{(WIDTH-1){1'b0}}, ~add_carry}; carry = add_carry; end
            ALU_SLL:  Result = A << shamt;
            ALU_SRL:  Result = A >> shamt;
            ALU_SRA:  Result = WIDTH'($signed(A) >>> shamt);
            default:  Result = '0;
        endcase
        Zero = ~|Result;
    end

    // Status register: captures the current result and flags when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result_q <= '0;
            Zero_q   <= 1'b1;
            Carry_q  <= 1'b0;
            Ovf_q    <= 1'b0;
        end else if (En) begin
            Result_q <= Result;
            Zero_q   <= Zero;
            Carry_q  <= carry;
            Ovf_q    <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reference model feeds a scoreboard queue, checked after each capture.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [3:0]  ALUControl;
    logic        En;
    logic [31:0] Result, Result_q;
    logic        Zero, Zero_q, Carry_q, Ovf_q;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb_q[$];

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .En         (En),
        .Result     (Result),
        .Zero       (Zero),
        .Result_q   (Result_q),
        .Zero_q     (Zero_q),
        .Carry_q    (Carry_q),
        .Ovf_q      (Ovf_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural reference using wide arithmetic and direct comparisons.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        logic [32:0] s;
        longint      sr;
        int          sh;
        sh    = int'(b[4:0]);
        m.res = '0;
        m.c   = 1'b0;
        m.v   = 1'b0;
        case (op)
            4'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                m.res = s[31:0];
                m.c   = s[32];
                sr    = longint'($signed(a)) + longint'($signed(b));
                m.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                m.res = a - b;
                m.c   = (a >= b);
                sr    = longint'($signed(a)) - longint'($signed(b));
                m.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: m.res = a & b;
            4'd3: m.res = a | b;
            4'd4: m.res = a ^ b;
            4'd5: begin m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; m.c = (a >= b); end
            4'd6: begin m.res = (a < b) ? 32'd1 : 32'd0; m.c = (a >= b); end
            4'd7: m.res = a << sh;
            4'd8: m.res = a >> sh;
            4'd9: m.res = 32'($signed(a) >>> sh);
            default: m.res = '0;
        endcase
        m.z = (m.res == 32'd0);
        return m;
    endfunction

    // Drive one op with En=1, then check combinational and captured outputs after the edge.
    task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        A = a; B = b; ALUControl = op; En = 1'b1;
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".res"},   Result,          e.res);
        chk({tag, ".zero"},  {31'd0, Zero},   {31'd0, e.z});
        chk({tag, ".res_q"}, Result_q,        e.res);
        chk({tag, ".flags"}, {28'd0, Zero_q, Carry_q, Ovf_q}, {28'd0, e.z, e.c, e.v});
    endtask

    initial begin
        rst_n = 1'b0; En = 1'b0; A = '0; B = '0; ALUControl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.res_q", Result_q, 32'd0);
        chk("rst.flags", {28'd0, Zero_q, Carry_q, Ovf_q}, 32'b100);

        @(negedge clk);
        rst_n = 1'b1;

        // Register: first capture right after reset release, then hold with En=0.
        apply("add10_20", 4'd0, 32'd10, 32'd20);
        chk("add10_20.lit", Result_q, 32'd30);
        @(negedge clk);
        En = 1'b0; A = 32'd7; B = 32'd9;
        @(posedge clk);
        #1;
        chk("hold.res_q", Result_q, 32'd30);
        chk("hold.comb",  Result,   32'd16);

        apply("add_wrap",  4'd0, 32'hFFFF_FFFF, 32'd1);
        apply("sub50_20",  4'd1, 32'd50, 32'd20);
        apply("sub50_50",  4'd1, 32'd50, 32'd50);
        apply("sub_ovf",   4'd1, 32'h8000_0000, 32'd1);
        chk("sub_ovf.lit", {Result_q[31:0]}, 32'h7FFF_FFFF);
        chk("sub_ovf.v",   {31'd0, Ovf_q}, 32'd1);
        apply("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1);
        apply("slt_lt",    4'd5, 32'd10, 32'd20);
        apply("slt_gt",    4'd5, 32'd20, 32'd10);
        apply("slt_neg",   4'd5, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg.lit", Result, 32'd1);
        apply("sltu_neg",  4'd6, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_neg.lit", Result, 32'd0);
        apply("slt_ext",   4'd5, 32'h8000_0000, 32'h7FFF_FFFF);
        chk("slt_ext.lit", Result, 32'd1);
        apply("and",       4'd2, 32'hA, 32'hC);
        apply("or",        4'd3, 32'hA, 32'hC);
        apply("xor",       4'd4, 32'hA, 32'hC);
        chk("xor.lit", Result, 32'h6);
        apply("illegal15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        apply("illegal10", 4'd10, 32'hFFFF_FFFF, 32'h1);
        apply("sll",       4'd7, 32'h8000_0000, 32'h24);
        apply("srl",       4'd8, 32'h8000_0000, 32'h24);
        chk("srl.lit", Result, 32'h0800_0000);
        apply("sra",       4'd9, 32'h8000_0000, 32'h24);
        chk("sra.lit", Result, 32'hF800_0000);
        apply("sra_sh0",   4'd9, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        apply("sll_sh31",  4'd7, 32'h0000_0003, 32'h1F);

        // Random sweep over all 16 codes.
        for (int i = 0; i < 60; i++) begin
            apply("rand", 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        // Reset mid-cycle clears immediately, without waiting for an edge.
        apply("pre_rst", 4'd0, 32'h100, 32'h23);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.res_q", Result_q, 32'd0);
        chk("midrst.flags", {28'd0, Zero_q, Carry_q, Ovf_q}, 32'b100);
        @(posedge clk);
        #1;
        chk("midrst.held", Result_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 4'd1, 32'd5, 32'd3);

        if (sb_q.size() != 0) chk("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
